// File: rtl/spi_xform_slave.sv
// SPI mode-0 loopback slave: receives a DATA_W-bit word MSB-first, then returns f(mode, word) in the next frame.
// Latency: 3 clocks from pin to strobe, miso 1 clock after fall strobe; no backpressure, the SPI master paces everything.
module spi_xform_slave #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [1:0]        mode,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, TX = 2'd2} state_t;

    state_t state, state_nxt;

    logic sck_s1, sck_s, sck_d;
    logic ss_s1, ss_s;
    logic mosi_s1, mosi_s;
    logic rise, fall;

    logic [CW-1:0]     cnt;
    logic [DATA_W-2:0] shift_in;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] word;
    logic              rx_done, tx_done;

    function automatic logic [DATA_W-1:0] xform(input logic [1:0] m, input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] res;
        res = '0;
        case (m)
            2'd0: for (int i = 0; i < DATA_W; i++) res[i] = w[DATA_W-1-i];
            2'd1: res = w;
            2'd2: res = ~w;
            default: for (int i = 0; i < DATA_W; i++) res = res + {{(DATA_W-1){1'b0}}, w[i]};
        endcase
        return res;
    endfunction

    // ss synchronises to 1 so the slave stays idle until a real assertion is seen
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sck_s1  <= 1'b0;
            sck_s   <= 1'b0;
            sck_d   <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s  <= 1'b0;
        end else begin
            sck_s1  <= sck;
            sck_s   <= sck_s1;
            sck_d   <= sck_s;
            ss_s1   <= ss;
            ss_s    <= ss_s1;
            mosi_s1 <= mosi;
            mosi_s  <= mosi_s1;
        end
    end

    assign rise = sck_s & ~sck_d;
    assign fall = ~sck_s & sck_d;
    assign word = {shift_in, mosi_s};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ss_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = RX;
                RX:      if (rx_done) state_nxt = TX;
                TX:      if (tx_done) state_nxt = RX;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A deasserted ss suppresses both frame-completion strobes, so ss wins over a coincident edge
    always_comb begin
        rx_done = 1'b0;
        tx_done = 1'b0;
        if (!ss_s && rise && cnt == LAST) begin
            rx_done = (state == RX);
            tx_done = (state == TX);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            shift_in <= '0;
            tx_shift <= '0;
            miso     <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ss_s || state == IDLE) begin
                cnt  <= '0;
                miso <= 1'b1;
            end else if (state == RX) begin
                if (fall) miso <= 1'b1;
                if (rise) begin
                    if (rx_done) begin
                        rx_data  <= word;
                        rx_valid <= 1'b1;
                        tx_shift <= xform(mode, word);
                        cnt      <= '0;
                    end else begin
                        shift_in <= word[DATA_W-2:0];
                        cnt      <= cnt + CW'(1);
                    end
                end
            end else begin
                if (fall) begin
                    miso     <= tx_shift[DATA_W-1];
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                end
                if (rise) cnt <= tx_done ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_xform_slave.sv
// Directed bench for spi_xform_slave: an 8-bit and a 16-bit instance share sck/mosi, each with its own ss.
module tb_spi_xform_slave;

    localparam int HALF  = 8;
    localparam int SETUP = 6;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        ss8 = 1'b1;
    logic        ss16 = 1'b1;
    logic        miso8, miso16;
    logic [7:0]  rx_data8;
    logic [15:0] rx_data16;
    logic        rx_valid8, rx_valid16;

    int checks = 0;
    int errors = 0;
    int pv8 = 0;
    int pv16 = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rx_valid8)  pv8  = pv8 + 1;
        if (rx_valid16) pv16 = pv16 + 1;
    end

    spi_xform_slave #(.DATA_W(8)) dut8 (
        .clock(clock), .resetn(resetn), .mode(mode), .sck(sck), .ss(ss8), .mosi(mosi),
        .miso(miso8), .rx_data(rx_data8), .rx_valid(rx_valid8)
    );

    spi_xform_slave #(.DATA_W(16)) dut16 (
        .clock(clock), .resetn(resetn), .mode(mode), .sck(sck), .ss(ss16), .mosi(mosi),
        .miso(miso16), .rx_data(rx_data16), .rx_valid(rx_valid16)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Mode-0 master: drive mosi in the low phase, sample miso just before raising sck
    task automatic xfer(input bit sel16, input int n, input logic [31:0] tx, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            wait_clk(HALF);
            rx[i] = sel16 ? miso16 : miso8;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic set_ss(input bit sel16, input logic v);
        if (sel16) ss16 = v;
        else       ss8  = v;
        wait_clk(SETUP);
    endtask

    task automatic pair(input bit sel16, input logic [31:0] w, output logic [31:0] reply);
        logic [31:0] dummy;
        int n;
        n = sel16 ? 16 : 8;
        xfer(sel16, n, w, dummy);
        xfer(sel16, n, 32'd0, reply);
    endtask

    task automatic test_reset;
        checks++; if (miso8 !== 1'b1)     begin errors++; $display("FAIL reset_miso got %b want 1", miso8); end
        checks++; if (rx_data8 !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data8); end
        checks++; if (rx_valid8 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid8); end
        checks++; if (miso16 !== 1'b1)    begin errors++; $display("FAIL reset_miso16 got %b want 1", miso16); end
    endtask

    task automatic test_bitrev;
        logic [31:0] r;
        mode = 2'd0;
        pv8 = 0;
        set_ss(1'b0, 1'b0);
        pair(1'b0, 32'h01, r);
        wait_clk(SETUP);
        set_ss(1'b0, 1'b1);
        checks++; if (pv8 != 1)           begin errors++; $display("FAIL bitrev_pulses got %0d want 1", pv8); end
        checks++; if (rx_data8 !== 8'h01) begin errors++; $display("FAIL bitrev_rx_data got %h want 01", rx_data8); end
        checks++; if (r[7:0] !== 8'h80)   begin errors++; $display("FAIL bitrev_reply got %h want 80", r[7:0]); end
        checks++; if (miso8 !== 1'b1)     begin errors++; $display("FAIL bitrev_idle_miso got %b want 1", miso8); end
    endtask

    task automatic test_modes;
        logic [1:0] m   [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        logic [7:0] din [4] = '{8'hA5, 8'h0F, 8'hFF, 8'h00};
        logic [7:0] dexp[4] = '{8'hA5, 8'hF0, 8'h08, 8'h00};
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            mode = m[k];
            set_ss(1'b0, 1'b0);
            pair(1'b0, {24'd0, din[k]}, r);
            wait_clk(SETUP);
            set_ss(1'b0, 1'b1);
            checks++; if (r[7:0] !== dexp[k])
                begin errors++; $display("FAIL mode%0d_reply in %h got %h want %h", m[k], din[k], r[7:0], dexp[k]); end
            checks++; if (rx_data8 !== din[k])
                begin errors++; $display("FAIL mode%0d_rx_data got %h want %h", m[k], rx_data8, din[k]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1, r2;
        mode = 2'd0;
        pv8 = 0;
        set_ss(1'b0, 1'b0);
        pair(1'b0, 32'h12, r1);
        pair(1'b0, 32'h34, r2);
        wait_clk(SETUP);
        set_ss(1'b0, 1'b1);
        checks++; if (r1[7:0] !== 8'h48)  begin errors++; $display("FAIL b2b_reply1 got %h want 48", r1[7:0]); end
        checks++; if (r2[7:0] !== 8'h2C)  begin errors++; $display("FAIL b2b_reply2 got %h want 2c", r2[7:0]); end
        checks++; if (pv8 != 2)           begin errors++; $display("FAIL b2b_pulses got %0d want 2", pv8); end
        checks++; if (rx_data8 !== 8'h34) begin errors++; $display("FAIL b2b_rx_data got %h want 34", rx_data8); end
    endtask

    task automatic test_abort;
        logic [31:0] r;
        mode = 2'd0;
        pv8 = 0;
        set_ss(1'b0, 1'b0);
        xfer(1'b0, 5, 32'h1F, r);
        set_ss(1'b0, 1'b1);
        wait_clk(SETUP);
        checks++; if (pv8 != 0)           begin errors++; $display("FAIL abort_pulses got %0d want 0", pv8); end
        checks++; if (miso8 !== 1'b1)     begin errors++; $display("FAIL abort_miso got %b want 1", miso8); end
        checks++; if (rx_data8 !== 8'h34) begin errors++; $display("FAIL abort_rx_data got %h want 34", rx_data8); end
        set_ss(1'b0, 1'b0);
        pair(1'b0, 32'h3C, r);
        wait_clk(SETUP);
        set_ss(1'b0, 1'b1);
        checks++; if (r[7:0] !== 8'h3C)   begin errors++; $display("FAIL abort_next_reply got %h want 3c", r[7:0]); end
        checks++; if (pv8 != 1)           begin errors++; $display("FAIL abort_next_pulses got %0d want 1", pv8); end
    endtask

    task automatic test_reset_mid_tx;
        logic [31:0] r;
        mode = 2'd0;
        set_ss(1'b0, 1'b0);
        xfer(1'b0, 8, 32'hAA, r);
        xfer(1'b0, 3, 32'd0, r);
        checks++; if (r[2:0] !== 3'b010) begin errors++; $display("FAIL midtx_partial got %b want 010", r[2:0]); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (miso8 !== 1'b1)     begin errors++; $display("FAIL midtx_async_miso got %b want 1", miso8); end
        checks++; if (rx_data8 !== 8'h00) begin errors++; $display("FAIL midtx_async_rx_data got %h want 00", rx_data8); end
        ss8 = 1'b1;
        wait_clk(4);
        resetn = 1'b1;
        wait_clk(SETUP);
        set_ss(1'b0, 1'b0);
        pair(1'b0, 32'h01, r);
        wait_clk(SETUP);
        set_ss(1'b0, 1'b1);
        checks++; if (r[7:0] !== 8'h80)   begin errors++; $display("FAIL midtx_fresh_reply got %h want 80", r[7:0]); end
        checks++; if (rx_data8 !== 8'h01) begin errors++; $display("FAIL midtx_fresh_rx_data got %h want 01", rx_data8); end
    endtask

    task automatic test_w16;
        logic [31:0] r;
        mode = 2'd0;
        pv16 = 0;
        set_ss(1'b1, 1'b0);
        pair(1'b1, 32'h0001, r);
        wait_clk(SETUP);
        set_ss(1'b1, 1'b1);
        checks++; if (r[15:0] !== 16'h8000)   begin errors++; $display("FAIL w16_reply got %h want 8000", r[15:0]); end
        checks++; if (rx_data16 !== 16'h0001) begin errors++; $display("FAIL w16_rx_data got %h want 0001", rx_data16); end
        checks++; if (pv16 != 1)              begin errors++; $display("FAIL w16_pulses got %0d want 1", pv16); end
    endtask

    initial begin
        wait_clk(3);
        test_reset;
        resetn = 1'b1;
        wait_clk(SETUP);
        test_bitrev;
        test_modes;
        test_back_to_back;
        test_abort;
        test_reset_mid_tx;
        test_w16;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xform_slave.md
# spi_xform_slave

Parametrised SPI slave test peripheral, successor to the fixed 8-bit bit-reversal slave. It oversamples the SPI pins in the system clock domain and receives a DATA_W-bit word MSB-first. It returns a transformed word (bit-reverse, echo, invert or popcount) in the next DATA_W-bit frame and repeats the RX/TX frame pair for as long as ss stays asserted. It sits on the SoC SPI master's chip-select line as a loopback target for driver and master verification.

## Interface
- DATA_W, 8, word width in bits; legal range 4..32.
- clock  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- mode  in  2  transform select: 0 bit-reverse, 1 echo, 2 bitwise invert, 3 popcount. Sampled at RX completion.
- sck  in  1  SPI clock, asynchronous to clock, mode 0 (CPOL=0, CPHA=0).
- ss  in  1  chip select, active-low, asynchronous.
- mosi  in  1  master data out, asynchronous.
- miso  out  1  slave data, registered.
- rx_data  out  DATA_W  last completed received word.
- rx_valid  out  1  one-clock pulse when rx_data updates.

## Operation
- sck, ss and mosi each pass through a 2-flop synchroniser.
- Edge detect on synchronised sck uses one extra flop and produces rise and fall strobes.
- States:
  - IDLE: entered on reset or whenever synchronised ss is 1.
  - RX: entered when ss is 0; bit counter cleared.
  - TX
- RX:
  - On each rise, shift_in <= {shift_in[DATA_W-2:0], mosi_s} and increment the counter.
  - On the DATA_W-th rise:
    - rx_data <= completed word; pulse rx_valid.
    - tx_shift <= f(mode, word); counter cleared; go to TX.
- Transform f:
  - mode 0: result[i] = word[DATA_W-1-i].
  - mode 1: word.
  - mode 2: ~word.
  - mode 3: number of 1 bits in word, zero-extended to DATA_W.
- TX:
  - On each fall, miso <= tx_shift[DATA_W-1] and tx_shift shifts left. The first fall after entering TX drives the result MSB.
  - Each rise increments the counter. On the DATA_W-th rise, counter clears and state returns to RX for the next frame within the same ss assertion.
- miso:
  - Held 1 in IDLE and in RX.
  - Driven 1 on the first fall after leaving TX.
- ss high at any point, synchronised: go to IDLE immediately, discard the partial word, no rx_valid, miso <= 1. rx_data keeps its last value.
- Reset values:
  - state IDLE, counter 0, shift_in 0, tx_shift 0.
  - miso 1, rx_data 0, rx_valid 0.
- Counter width $clog2(DATA_W)+1; it never wraps within a frame.
- ss and an sck edge in the same clock: ss wins.
- mode changes are ignored except at the RX-completion clock.

## Timing
- Pin-to-strobe latency is 3 clocks (2 sync + 1 edge detect).
- miso changes 1 clock after the fall strobe, i.e. 4 clocks after the pin fall.
- Requirement: each sck high and low phase lasts at least 6 clocks. The ss setup before the first sck rise and the hold after the last fall are at least 4 clocks each.
- rx_valid is asserted exactly one clock, in the clock after the DATA_W-th RX rise strobe.
- TX begins at the first fall after RX completes. No dead sck cycles are needed between the RX and TX frames or between consecutive pairs.

## Test plan
- DATA_W=8, mode 0:
  - Send 0x01 -> rx_valid once, rx_data=0x01.
  - The next 8 sck cycles read 0x80 on miso.
- Mode 1, 0xA5 -> reply 0xA5.
- Mode 2, 0x0F -> reply 0xF0.
- Mode 3, 0xFF -> reply 0x08; 0x00 -> reply 0x00.
- Back-to-back pairs in one ss assertion:
  - Send 0x12, read 0x48; send 0x34, read 0x2C.
  - Exactly 2 rx_valid pulses.
- Abort:
  - Raise ss after 5 RX bits -> no rx_valid, miso=1.
  - Next assertion: send 0x3C -> reply 0x3C (mode 0).
- resetn low mid-TX -> miso=1 and rx_data=0 asynchronously. After release, a fresh frame works normally.
- Protocol check with DATA_W=16, mode 0: 0x0001 -> 0x8000.
